// File: rtl/regfile_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : regfile_scoreboard
// Brief    : 32 x N register file with two combinational read ports, one
//            writeback port and a per-register pending (scoreboard) bit that
//            is set on issue and cleared on writeback.
//            Optional macro REGFILE_BYPASS_EN adds same-cycle forwarding of
//            writeback data and busy suppression onto the read ports.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_scoreboard #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [4:0]   rd_addr1,
  input  logic [4:0]   rd_addr2,
  output logic [N-1:0] rd_data1,
  output logic [N-1:0] rd_data2,
  input  logic         wr_ena,
  input  logic [4:0]   wr_addr,
  input  logic [N-1:0] wr_data,
  input  logic         issue_ena,
  input  logic [4:0]   issue_addr,
  output logic         rs1_busy,
  output logic         rs2_busy
);

  // Register storage and pending bits, with their next-state values.
  logic [N-1:0] regs_q [32];
  logic [N-1:0] regs_d [32];
  logic [31:0]  pend_q;
  logic [31:0]  pend_d;

  // One-hot decodes of the writeback and issue destinations (x0 excluded).
  logic [31:0]  w_wr_sel;
  logic [31:0]  w_issue_sel;

  assign w_wr_sel[0]    = 1'b0;
  assign w_issue_sel[0] = 1'b0;

  for (genvar gi = 1; gi < 32; gi++) begin : g_dec
    assign w_wr_sel[gi]    = wr_ena    && (wr_addr    == 5'(gi));
    assign w_issue_sel[gi] = issue_ena && (issue_addr == 5'(gi));
  end

  // Next-state: writeback updates data and clears pending; a same-cycle issue
  // to the same register is applied last so the new producer keeps it busy.
  always_comb begin
    for (int i = 0; i < 32; i++) begin
      regs_d[i] = regs_q[i];
    end
    pend_d = pend_q;
    for (int i = 1; i < 32; i++) begin
      if (w_wr_sel[i]) begin
        regs_d[i] = wr_data;
        pend_d[i] = 1'b0;
      end
      if (w_issue_sel[i]) begin
        pend_d[i] = 1'b1;
      end
    end
    regs_d[0] = '0;
    pend_d[0] = 1'b0;
  end

  // State register with synchronous reset taking priority over all updates.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= '0;
      end
      pend_q <= '0;
    end else begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= regs_d[i];
      end
      pend_q <= pend_d;
    end
  end

  // Stored-state read values; x0 is hard-wired to zero and never pending.
  logic [N-1:0] w_rf_data1;
  logic [N-1:0] w_rf_data2;
  logic         w_rf_busy1;
  logic         w_rf_busy2;

  // Combinational 32:1 selection for both read ports.
  always_comb begin
    w_rf_data1 = '0;
    w_rf_data2 = '0;
    w_rf_busy1 = 1'b0;
    w_rf_busy2 = 1'b0;
    if (rd_addr1 != 5'd0) begin
      w_rf_data1 = regs_q[rd_addr1];
      w_rf_busy1 = pend_q[rd_addr1];
    end
    if (rd_addr2 != 5'd0) begin
      w_rf_data2 = regs_q[rd_addr2];
      w_rf_busy2 = pend_q[rd_addr2];
    end
  end

`ifdef REGFILE_BYPASS_EN
  // A writeback in flight to the addressed register is forwarded; the
  // register then reads not-busy unless a new producer issues to it now.
  logic w_fwd1;
  logic w_fwd2;
  logic w_reissue;

  assign w_fwd1    = wr_ena && (wr_addr != 5'd0) && (wr_addr == rd_addr1);
  assign w_fwd2    = wr_ena && (wr_addr != 5'd0) && (wr_addr == rd_addr2);
  assign w_reissue = issue_ena && (issue_addr == wr_addr);

  // Output selection between forwarded and stored values.
  always_comb begin
    rd_data1 = w_rf_data1;
    rd_data2 = w_rf_data2;
    rs1_busy = w_rf_busy1;
    rs2_busy = w_rf_busy2;
    if (w_fwd1) begin
      rd_data1 = wr_data;
      rs1_busy = w_reissue;
    end
    if (w_fwd2) begin
      rd_data2 = wr_data;
      rs2_busy = w_reissue;
    end
  end
`else
  // Without forwarding, reads reflect the state before the coming edge.
  always_comb begin
    rd_data1 = w_rf_data1;
    rd_data2 = w_rf_data2;
    rs1_busy = w_rf_busy1;
    rs2_busy = w_rf_busy2;
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_regfile_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_scoreboard
// Brief    : Self-checking bench for regfile_scoreboard: directed scenarios
//            followed by random traffic, checked against an array model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_scoreboard;

  localparam int N = 32;

  logic         clk;
  logic         rst;
  logic [4:0]   rd_addr1;
  logic [4:0]   rd_addr2;
  logic [N-1:0] rd_data1;
  logic [N-1:0] rd_data2;
  logic         wr_ena;
  logic [4:0]   wr_addr;
  logic [N-1:0] wr_data;
  logic         issue_ena;
  logic [4:0]   issue_addr;
  logic         rs1_busy;
  logic         rs2_busy;

  int vectors;
  int miscompares;

  // Reference model: plain register contents and pending flags.
  logic [N-1:0] m_reg  [32];
  bit           m_pend [32];

  regfile_scoreboard #(.N(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .rd_addr1   (rd_addr1),
    .rd_addr2   (rd_addr2),
    .rd_data1   (rd_data1),
    .rd_data2   (rd_data2),
    .wr_ena     (wr_ena),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .issue_ena  (issue_ena),
    .issue_addr (issue_addr),
    .rs1_busy   (rs1_busy),
    .rs2_busy   (rs2_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected read data for an address given the current inputs.
  function automatic logic [N-1:0] exp_data(input logic [4:0] a);
`ifdef REGFILE_BYPASS_EN
    if (wr_ena && wr_addr != 0 && wr_addr == a) return wr_data;
`endif
    if (a == 0) return '0;
    return m_reg[a];
  endfunction

  // Expected busy flag for an address given the current inputs.
  function automatic logic exp_busy(input logic [4:0] a);
`ifdef REGFILE_BYPASS_EN
    if (wr_ena && wr_addr != 0 && wr_addr == a)
      return issue_ena && (issue_addr == wr_addr);
`endif
    if (a == 0) return 1'b0;
    return m_pend[a];
  endfunction

  task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Model update at a rising edge.
  task automatic model_edge();
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        m_reg[i]  = '0;
        m_pend[i] = 1'b0;
      end
    end else begin
      if (wr_ena && wr_addr != 0) m_reg[wr_addr] = wr_data;
      if (wr_ena) m_pend[wr_addr] = 1'b0;
      if (issue_ena && issue_addr != 0) m_pend[issue_addr] = 1'b1;
    end
  endtask

  // Apply one cycle: drive inputs, check reads mid-cycle, then clock.
  task automatic step(input logic r, input logic we, input logic [4:0] wa,
                      input logic [N-1:0] wd, input logic ie, input logic [4:0] ia,
                      input logic [4:0] a1, input logic [4:0] a2,
                      output logic [N-1:0] o_d1, output logic [N-1:0] o_d2,
                      output logic o_b1, output logic o_b2);
    rst = r; wr_ena = we; wr_addr = wa; wr_data = wd;
    issue_ena = ie; issue_addr = ia; rd_addr1 = a1; rd_addr2 = a2;
    @(negedge clk);
    o_d1 = rd_data1; o_d2 = rd_data2; o_b1 = rs1_busy; o_b2 = rs2_busy;
    check("rd_data1", rd_data1, exp_data(a1));
    check("rd_data2", rd_data2, exp_data(a2));
    check("rs1_busy", N'(rs1_busy), N'(exp_busy(a1)));
    check("rs2_busy", N'(rs2_busy), N'(exp_busy(a2)));
    @(posedge clk);
    model_edge();
    #1;
  endtask

  logic [N-1:0] d1, d2;
  logic         b1, b2;

  initial begin
    vectors = 0;
    miscompares = 0;
    for (int i = 0; i < 32; i++) begin
      m_reg[i]  = '0;
      m_pend[i] = 1'b0;
    end
    rst = 1'b1; wr_ena = 0; wr_addr = 0; wr_data = 0;
    issue_ena = 0; issue_addr = 0; rd_addr1 = 0; rd_addr2 = 0;
    @(posedge clk); #1;

    // Reset with a pending write and issue in the same cycle.
    step(1, 1, 5'd3, 32'hFFFF_FFFF, 1, 5'd3, 5'd0, 5'd0, d1, d2, b1, b2);
    for (int i = 0; i < 32; i++) begin
      step(0, 0, 5'd0, '0, 0, 5'd0, 5'(i), 5'(31 - i), d1, d2, b1, b2);
      check("reset_data", d1 | d2, '0);
      check("reset_busy", N'(b1 | b2), '0);
    end

    // Write then read on both ports; write to x0 is discarded.
    step(0, 1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 5'd0, 5'd0, d1, d2, b1, b2);
    step(0, 0, 5'd0, '0, 0, 5'd0, 5'd5, 5'd5, d1, d2, b1, b2);
    check("wr5_port1", d1, 32'hDEADBEEF);
    check("wr5_port2", d2, 32'hDEADBEEF);
    step(0, 1, 5'd0, 32'h12345678, 0, 5'd0, 5'd0, 5'd0, d1, d2, b1, b2);
    step(0, 0, 5'd0, '0, 0, 5'd0, 5'd0, 5'd0, d1, d2, b1, b2);
    check("x0_zero", d1, '0);

    // Scoreboard set by issue and cleared by writeback; x0 never busy.
    step(0, 0, 5'd0, '0, 1, 5'd7, 5'd0, 5'd0, d1, d2, b1, b2);
    step(0, 0, 5'd0, '0, 0, 5'd0, 5'd7, 5'd0, d1, d2, b1, b2);
    check("issue7_busy", N'(b1), N'(1'b1));
    step(0, 1, 5'd7, 32'h55, 0, 5'd0, 5'd0, 5'd0, d1, d2, b1, b2);
    step(0, 0, 5'd0, '0, 0, 5'd0, 5'd7, 5'd0, d1, d2, b1, b2);
    check("wb7_busy", N'(b1), '0);
    check("wb7_data", d1, 32'h55);
    step(0, 0, 5'd0, '0, 1, 5'd0, 5'd0, 5'd0, d1, d2, b1, b2);
    step(0, 0, 5'd0, '0, 0, 5'd0, 5'd0, 5'd0, d1, d2, b1, b2);
    check("issue0_busy", N'(b1), '0);

    // Collision: issue and writeback to pending x9 in the same cycle.
    step(0, 0, 5'd0, '0, 1, 5'd9, 5'd0, 5'd0, d1, d2, b1, b2);
    step(0, 1, 5'd9, 32'hA5, 1, 5'd9, 5'd0, 5'd0, d1, d2, b1, b2);
    step(0, 0, 5'd0, '0, 0, 5'd0, 5'd0, 5'd9, d1, d2, b1, b2);
    check("collide_busy", N'(b2), N'(1'b1));
    check("collide_data", d2, 32'hA5);

    // WAW: double issue, single writeback clears.
    step(0, 0, 5'd0, '0, 1, 5'd10, 5'd0, 5'd0, d1, d2, b1, b2);
    step(0, 0, 5'd0, '0, 1, 5'd10, 5'd10, 5'd0, d1, d2, b1, b2);
    step(0, 1, 5'd10, 32'h1, 0, 5'd0, 5'd0, 5'd0, d1, d2, b1, b2);
    step(0, 0, 5'd0, '0, 0, 5'd0, 5'd10, 5'd10, d1, d2, b1, b2);
    check("waw_busy", N'(b1), '0);

    // Same-cycle read of a register being written.
    step(0, 1, 5'd3, 32'h11, 0, 5'd0, 5'd0, 5'd0, d1, d2, b1, b2);
    step(0, 1, 5'd3, 32'h22, 0, 5'd0, 5'd3, 5'd0, d1, d2, b1, b2);
`ifdef REGFILE_BYPASS_EN
    check("bypass_data", d1, 32'h22);
`else
    check("bypass_data", d1, 32'h11);
`endif

    // Reset mid-operation discards a same-cycle writeback.
    step(0, 1, 5'd4, 32'h99, 1, 5'd4, 5'd0, 5'd0, d1, d2, b1, b2);
    step(1, 1, 5'd4, 32'h77, 0, 5'd0, 5'd0, 5'd0, d1, d2, b1, b2);
    step(0, 0, 5'd0, '0, 0, 5'd0, 5'd4, 5'd4, d1, d2, b1, b2);
    check("rstmid_data", d1, '0);
    check("rstmid_busy", N'(b1), '0);

    // Random traffic against the model; addresses biased to a small set.
    for (int k = 0; k < 400; k++) begin
      logic [4:0] wa, ia, a1, a2;
      wa = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 5));
      ia = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 5));
      a1 = ($urandom_range(0, 1) == 0) ? wa : 5'($urandom_range(0, 7));
      a2 = ($urandom_range(0, 1) == 0) ? ia : 5'($urandom);
      step(($urandom_range(0, 49) == 0), 1'($urandom), wa, N'($urandom),
           1'($urandom), ia, a1, a2, d1, d2, b1, b2);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/regfile_scoreboard.md
REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

Interface
REQ-001 SHALL have parameter N, default 32, the data width of every register and data port.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port rd_addr1  input  5  read port 1 register index.
REQ-005 SHALL have port rd_addr2  input  5  read port 2 register index.
REQ-006 SHALL have port rd_data1  output  N  read port 1 data.
REQ-007 SHALL have port rd_data2  output  N  read port 2 data.
REQ-008 SHALL have port wr_ena  input  1  writeback enable.
REQ-009 SHALL have port wr_addr  input  5  writeback register index.
REQ-010 SHALL have port wr_data  input  N  writeback data.
REQ-011 SHALL have port issue_ena  input  1  an instruction with destination issue_addr was issued.
REQ-012 SHALL have port issue_addr  input  5  issued destination register index.
REQ-013 SHALL have port rs1_busy  output  1  register at rd_addr1 awaits writeback.
REQ-014 SHALL have port rs2_busy  output  1  register at rd_addr2 awaits writeback.

Function
REQ-015 SHALL hold 32 registers x0..x31 of N bits plus one pending bit per register.
REQ-016 SHALL drive rd_data1/rd_data2 combinationally from the register selected by rd_addr1/rd_addr2 via 32:1 selection; zero-cycle read latency.
REQ-017 SHALL read x0 as all-zeros and keep its pending bit 0 at all times.
REQ-018 SHALL write wr_data into register wr_addr at the rising edge when wr_ena=1 and wr_addr!=0; writes to x0 are discarded.
REQ-019 SHALL set pending[issue_addr] at the rising edge when issue_ena=1 and issue_addr!=0.
REQ-020 SHALL clear pending[wr_addr] at the rising edge when wr_ena=1, unless REQ-021 applies.
REQ-021 SHALL leave pending set when issue_ena=1, wr_ena=1 and issue_addr==wr_addr!=0 in the same cycle (new producer overrides completed one); data is still written.
REQ-022 SHALL allow issue of a register already pending (WAW): bit stays set; a single writeback clears it.
REQ-023 SHALL drive rs1_busy = pending[rd_addr1] and rs2_busy = pending[rd_addr2] combinationally, subject to REQ-029.
REQ-024 SHALL ignore wr_ena/issue_ena on a non-pending register only in the sense that writeback to a non-pending register still writes data and leaves pending 0.
REQ-025 SHALL support both read ports addressing the same register simultaneously with identical results.

Reset
REQ-026 SHALL, on rising edge with rst=1, clear all 32 registers to 0 and all pending bits to 0.
REQ-027 SHALL give rst priority over wr_ena and issue_ena in the same cycle; both are discarded.
REQ-028 SHALL present rd_data1=rd_data2=0 and rs1_busy=rs2_busy=0 for any addresses in the cycle after reset.

Configuration
REQ-029 SHALL, when macro REGFILE_BYPASS_EN is defined, forward wr_data to rd_dataK when wr_ena=1, wr_addr==rd_addrK, wr_addr!=0 in the same cycle, and force rsK_busy=0 in that case unless issue_ena=1 and issue_addr==wr_addr.
REQ-030 SHALL, when REGFILE_BYPASS_EN is undefined, provide no forwarding: reads return the pre-edge register value and busy reflects pre-edge pending bits.

Verification
REQ-031 Reset: rst=1 one cycle, then read all 32 addresses on both ports -> every rd_data=0, every busy=0.
REQ-032 Write/read: wr_ena=1 wr_addr=5 wr_data=0xDEADBEEF, next cycle rd_addr1=5 rd_addr2=5 -> both rd_data=0xDEADBEEF; write x0=0x12345678 -> x0 reads 0.
REQ-033 Scoreboard: issue_addr=7 -> next cycle rs1_busy=1 with rd_addr1=7; wr_ena wr_addr=7 wr_data=0x55 -> next cycle rs1_busy=0, rd_data1=0x55; issue_addr=0 -> busy stays 0.
REQ-034 Collision: x9 pending, same cycle issue_addr=9 and wr_addr=9 wr_data=0xA5 -> next cycle rs2_busy=1 (rd_addr2=9), rd_data2=0xA5.
REQ-035 Bypass: rd_addr1=3 holding 0x11, wr_ena wr_addr=3 wr_data=0x22 same cycle -> rd_data1=0x22 with REGFILE_BYPASS_EN, 0x11 without.
REQ-036 Reset mid-operation: x4=0x99 pending, rst=1 with wr_ena wr_addr=4 wr_data=0x77 -> next cycle x4 reads 0, rs1_busy=0.
